// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory initiator for the core's MEM stage.
// Converts byte-addressed byte/halfword/word loads and stores into accesses
// to a word-addressed memory with 1-cycle registered reads. Sub-word stores
// use read-modify-write, and sub-word loads are extended on return.
// Optional build macro: MISALIGN_TRAP_EN rejects misaligned halfword/word
// accesses with resp_err instead of silently aligning them.
//
// state  | meaning
// IDLE   | waiting for req_valid, busy low
// RD     | read address presented, memory word arrives next cycle
// MERGE  | sub-word store: write read word with new lane(s) spliced in
// WR     | full-word store: write strobe active
// LD_RET | load: select lane, extend, register into resp_rdata
// RESP   | resp_valid pulse, requests ignored this cycle
module mem_access_unit #(
    parameter int ADDR_W    = 13,
    parameter int BASE_WORD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, LD_RET, RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        size_q;
    logic [1:0]        lane_q;
    logic              sign_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic              mem_write_q;

    logic [31:0]       idx_sum;
    logic              misalign;
    logic [31:0]       ld_word;
    logic [31:0]       merged;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;

    // Word index with segment base; truncation to ADDR_W gives the wrap.
    assign idx_sum = {2'b00, req_addr[31:2]} + 32'(BASE_WORD);

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Load lane selection and sign/zero extension from the returned word.
    always_comb begin
        sel_byte = 8'h00;
        case (lane_q)
            2'd0:    sel_byte = mem_read_data[7:0];
            2'd1:    sel_byte = mem_read_data[15:8];
            2'd2:    sel_byte = mem_read_data[23:16];
            default: sel_byte = mem_read_data[31:24];
        endcase
        sel_half = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_q)
            2'b00:   ld_word = {{24{sign_q & sel_byte[7]}}, sel_byte};
            2'b01:   ld_word = {{16{sign_q & sel_half[15]}}, sel_half};
            default: ld_word = mem_read_data;
        endcase
    end

    // Sub-word store merge: splice the low byte/halfword of wdata into the read word.
    always_comb begin
        merged = mem_read_data;
        if (size_q == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // The merge write must use read data arriving in the MERGE cycle itself,
    // so that strobe is decoded from state; an async reset drops it at once.
    assign mem_write      = mem_write_q | (state == MERGE);
    assign mem_write_data = (state == MERGE) ? merged : wdata_q;
    assign mem_address    = {{(32-ADDR_W){1'b0}}, idx_q};

    // Request sequencing, latched request fields and registered responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx_q       <= '0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            sign_q      <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= 32'h0;
            mem_write_q <= 1'b0;
            busy        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 32'h0;
        end else begin
            mem_write_q <= 1'b0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        idx_q   <= idx_sum[ADDR_W-1:0];
                        size_q  <= req_size;
                        lane_q  <= req_addr[1:0];
                        sign_q  <= req_signed;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        if (misalign) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (req_write && req_size[1]) begin
                            busy        <= 1'b1;
                            mem_write_q <= 1'b1;
                            state       <= WR;
                        end else begin
                            busy  <= 1'b1;
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    state <= write_q ? MERGE : LD_RET;
                end
                MERGE, WR: begin
                    busy       <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                LD_RET: begin
                    resp_rdata <= ld_word;
                    busy       <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vectors, scoreboard for responses,
// inline timing checks for write strobes, addresses and response cycles.
// A second instance with BASE_WORD=8191 shares the request bus to check wrap.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        busy, resp_valid, resp_err, mem_write;
    logic [31:0] resp_rdata, mem_address, mem_write_data;
    logic [31:0] mem_read_data = 32'h0;

    logic        busy2, resp_valid2, resp_err2, mem_write2;
    logic [31:0] resp_rdata2, mem_address2, mem_write_data2;
    logic [31:0] mem_read_data2 = 32'h0;

    logic [31:0] mem [0:8191];
    logic [32:0] sb_q[$];
    logic [31:0] last_rd = 32'h0;
    int          checks = 0;
    int          errors = 0;
    int          wr_pulses = 0;

    mem_access_unit #(.ADDR_W(13), .BASE_WORD(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_write(mem_write),
        .mem_read_data(mem_read_data)
    );

    mem_access_unit #(.ADDR_W(13), .BASE_WORD(8191)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy2), .resp_valid(resp_valid2),
        .resp_rdata(resp_rdata2), .resp_err(resp_err2), .mem_address(mem_address2),
        .mem_write_data(mem_write_data2), .mem_write(mem_write2),
        .mem_read_data(mem_read_data2)
    );

    always #5 clk = ~clk;

    // Data memory model: write strobe and 1-cycle registered read.
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[12:0]] <= mem_write_data;
        mem_read_data <= mem[mem_address[12:0]];
        if (mem_write) wr_pulses++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop the expected response whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            logic [32:0] e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got err=%b rdata=%h with empty scoreboard", resp_err, resp_rdata);
            end else begin
                e = sb_q.pop_front();
                if ({resp_err, resp_rdata} !== e) begin
                    errors++;
                    $display("FAIL resp: got err=%b rdata=%h expected err=%b rdata=%h",
                             resp_err, resp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    // Issue one request and check strobe cycle, write data, address and response cycle.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_wr_c, input int exp_rs_c, input logic exp_err,
                         input logic [31:0] exp_rd, input logic [31:0] exp_wd);
        int wr_c = -1;
        int rs_c = -1;
        logic [31:0] wd = 32'h0;
        logic [31:0] rd_exp;
        logic [31:0] a_main;
        logic [31:0] a_wrap;
        rd_exp = (wr || exp_err) ? last_rd : exp_rd;
        last_rd = rd_exp;
        a_main = (addr >> 2) & 32'h1FFF;
        a_wrap = ((addr >> 2) + 32'd8191) & 32'h1FFF;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wdata;
        sb_q.push_back({exp_err, rd_exp});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("mem_address", mem_address, a_main);
                chk("mem_address_wrap", mem_address2, a_wrap);
            end
            if (mem_write && wr_c < 0) begin
                wr_c = c;
                wd = mem_write_data;
            end
            if (resp_valid) begin
                rs_c = c;
                chk("busy_in_resp", 32'(busy), 32'd0);
                break;
            end
        end
        chk("write_cycle", wr_c, exp_wr_c);
        chk("resp_cycle", rs_c, exp_rs_c);
        if (exp_wr_c >= 0) chk("write_data", wd, exp_wd);
    endtask

    initial begin
        logic [31:0] w5;
        int pulses0;
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_write_data", mem_write_data, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 2, 0, 32'h0, 32'hDEADBEEF);
        issue(0, 2'b10, 0, 32'h10, 32'h0, -1, 3, 0, 32'hDEADBEEF, 32'h0);
        mem[4] = 32'h11223344;
        issue(1, 2'b00, 0, 32'h12, 32'hFFFFFFAB, 2, 3, 0, 32'h0, 32'h11AB3344);
        issue(0, 2'b10, 0, 32'h10, 32'h0, -1, 3, 0, 32'h11AB3344, 32'h0);
        issue(1, 2'b01, 0, 32'h10, 32'h1234CAFE, 2, 3, 0, 32'h0, 32'h11ABCAFE);
        issue(0, 2'b01, 0, 32'h10, 32'h0, -1, 3, 0, 32'h0000CAFE, 32'h0);

        mem[0] = 32'h80FF7F01;
        issue(0, 2'b00, 1, 32'h0, 32'h0, -1, 3, 0, 32'h00000001, 32'h0);
        issue(0, 2'b00, 1, 32'h2, 32'h0, -1, 3, 0, 32'hFFFFFFFF, 32'h0);
        issue(0, 2'b00, 0, 32'h2, 32'h0, -1, 3, 0, 32'h000000FF, 32'h0);
        issue(0, 2'b01, 1, 32'h2, 32'h0, -1, 3, 0, 32'hFFFF80FF, 32'h0);
        issue(0, 2'b01, 0, 32'h2, 32'h0, -1, 3, 0, 32'h000080FF, 32'h0);
        issue(0, 2'b00, 1, 32'h1, 32'h0, -1, 3, 0, 32'h0000007F, 32'h0);
        issue(0, 2'b00, 1, 32'h3, 32'h0, -1, 3, 0, 32'hFFFFFF80, 32'h0);
        issue(0, 2'b00, 0, 32'h3, 32'h0, -1, 3, 0, 32'h00000080, 32'h0);
        issue(1, 2'b01, 0, 32'h2, 32'h5555BEEF, 2, 3, 0, 32'h0, 32'hBEEF7F01);
        issue(0, 2'b11, 0, 32'h0, 32'h0, -1, 3, 0, 32'hBEEF7F01, 32'h0);

        mem[2] = 32'h0BADF00D;
        issue(0, 2'b10, 0, 32'h8, 32'h0, -1, 3, 0, 32'h0BADF00D, 32'h0);

`ifdef MISALIGN_TRAP_EN
        issue(0, 2'b10, 0, 32'h13, 32'h0, -1, 1, 1, 32'h0, 32'h0);
        issue(0, 2'b01, 0, 32'h11, 32'h0, -1, 1, 1, 32'h0, 32'h0);
        issue(1, 2'b10, 0, 32'h12, 32'h99999999, -1, 1, 1, 32'h0, 32'h0);
        chk("trap_mem_unchanged", mem[4], 32'h11ABCAFE);
`else
        issue(0, 2'b10, 0, 32'h13, 32'h0, -1, 3, 0, 32'h11ABCAFE, 32'h0);
        issue(0, 2'b01, 0, 32'h11, 32'h0, -1, 3, 0, 32'h0000CAFE, 32'h0);
`endif

        // Reset in the MERGE cycle must suppress the pending write.
        mem[5] = 32'h55667788;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h14; req_wdata = 32'h00000099;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("merge_pending", 32'(mem_write), 32'd1);
        pulses0 = wr_pulses;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_rdata", resp_rdata, 32'h0);
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_mem_address", mem_address, 32'h0);
        chk("abort_mem_write_data", mem_write_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        w5 = mem[5];
        chk("abort_no_pulse", wr_pulses, pulses0);
        chk("abort_mem_unchanged", w5, 32'h55667788);
        last_rd = 32'h0;
        issue(0, 2'b10, 0, 32'h14, 32'h0, -1, 3, 0, 32'h55667788, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: takes byte/halfword/word load and store requests from the core's MEM stage and drives the word-addressed data memory.
- Data memory is 32-bit words, with a write strobe and a registered read of 1-cycle latency.
- Converts byte addresses to word indices, performs read-modify-write for sub-word stores, and extracts and extends sub-word loads.
- Returns results over a valid/busy handshake.

Parameters:
- ADDR_W, 13, width of the data-memory word index; mem_address[31:ADDR_W] is always driven 0.
- BASE_WORD, 0, word offset added to every computed word index (the segment base).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present; accepted only when busy==0.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as word).
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- busy  out  1  request in flight; new requests are ignored while high.
- resp_valid  out  1  one-cycle pulse on completion of any request.
- resp_rdata  out  32  load result, valid with resp_valid; holds until the next load response.
- resp_err  out  1  pulse with resp_valid when the access was rejected (see optional feature).
- mem_address  out  32  word index to the data memory.
- mem_write_data  out  32  word written to the data memory.
- mem_write  out  1  data-memory write strobe, one cycle.
- mem_read_data  in  32  data-memory read word; valid one cycle after mem_address is presented.

Behaviour:
- Reset values: busy=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_write=0, mem_address=0, mem_write_data=0; FSM=IDLE.
- Reset asserted mid-operation aborts the operation immediately; no write strobe is issued after rst_n falls.
- Word index: ((req_addr>>2) + BASE_WORD) truncated to ADDR_W bits, so it wraps modulo 2^ADDR_W. Index, size, signed flag, byte lane req_addr[1:0] and wdata are latched at accept.
- Byte lanes are little-endian: lane 0 = bits[7:0]. A halfword at lane 2 = bits[31:16].
- States:
  - IDLE: busy=0. On req_valid go to one of:
    - word store -> WR
    - sub-word store -> RD
    - load -> RD
    - error (feature enabled) -> RESP
  - RD: busy=1. mem_address is driven; wait one cycle for mem_read_data. Next state is LD_RET for a load, MERGE for a sub-word store.
  - MERGE: replace the addressed lane(s) of the captured read word with the low byte/halfword of wdata. Drive mem_write_data = merged word and mem_write=1 for this cycle, then go to RESP.
  - WR: mem_write_data=wdata, mem_write=1 for one cycle, then RESP.
  - LD_RET: select the lane, extend per req_signed, register into resp_rdata, then RESP.
  - RESP: resp_valid=1 for one cycle, busy=0 in this cycle; return to IDLE.
- Timing (accept cycle = 0):
  - word store: mem_write in cycle 1, resp_valid in cycle 2.
  - load: read in cycle 1, resp_rdata/resp_valid in cycle 3.
  - sub-word store: mem_write in cycle 2, resp_valid in cycle 3.
- No back-to-back accept: a request presented in the RESP cycle is ignored. The core must hold req_valid until busy falls after a response; the first accept after RESP is in IDLE.
- mem_address holds the latched index from accept until the next accept.
- mem_write is never asserted for loads or rejected requests.
- Stores leave resp_rdata unchanged.

Optional Feature:
- Macro: MISALIGN_TRAP_EN
- Defined:
  - halfword with req_addr[0]=1, or word with req_addr[1:0]!=0, goes IDLE->RESP with resp_err=1 and no memory access (resp_valid in cycle 1).
  - resp_rdata is unchanged on an error.
- Undefined:
  - low address bits below the access size are ignored (halfword uses lane bit 1 only; word ignores [1:0]).
  - resp_err is tied to 0.

Test Plan:
- Reset: drive rst_n=0 mid-MERGE with mem_write pending -> all outputs 0, no mem_write pulse, FSM in IDLE after release.
- Word store/load: store 0xDEADBEEF at byte addr 0x10 -> mem_address=4, mem_write in cycle 1. Then load word 0x10 -> resp_rdata=0xDEADBEEF in cycle 3.
- Byte store merge: memory word 4 = 0x11223344; store byte 0xAB at addr 0x12 -> mem_write_data=0x11AB3344 in cycle 2.
- Signed/unsigned loads from word 0x80FF7F01:
  - lb addr 0 -> 0x00000001
  - lb addr 2 -> 0xFFFFFFFF
  - lbu addr 2 -> 0x000000FF
  - lh addr 2 -> 0xFFFF80FF
  - lhu addr 2 -> 0x000080FF
- Wrap and base offset: BASE_WORD=8191, ADDR_W=13, load addr 0x8 -> mem_address=1.
- Misaligned access, lw at addr 0x13:
  - with MISALIGN_TRAP_EN: resp_valid+resp_err in cycle 1, no mem access.
  - without it: reads word 4, resp_err=0.
